shift_sequencer: RTL and testbench

- Multi-cycle controller that shares one single-step combinational shifter between NREQ requesters.
- Each accepted request (data plus shift amount) is iterated through the external shifter once per cycle until the amount is consumed.
- The result is returned on a valid/ready response channel tagged with the requester ID.
- Sits between client blocks and the shifter instance; the shifter's DATA/SHIFTED ports connect to SH_DATA/SH_SHIFTED here.

---
 rtl/shift_seq_pkg.sv | 12 +
 rtl/shift_sequencer_if.sv | 36 +++
 rtl/shift_seq_rr_arbiter.sv | 30 +++
 rtl/shift_sequencer.sv | 112 +++++++++++
 tb/tb_shift_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_seq_state_t;

  localparam int OP_COUNT_W = 16;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response/shifter bundle for shift_sequencer. The sequencer sits on the slave
// modport; clients, the response consumer and the shifter stand-in sit on master.
interface shift_sequencer_if
  import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int CNT_W = $clog2(WIDTH) + 1,
    parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    // Handshakes: a transfer happens on a posedge where VALID and READY are both high.
    // A source holds VALID and its payload stable until that edge; READY may be
    // driven freely and does not depend on a VALID from the same channel's future.
    logic [NREQ-1:0]         REQ_VALID;
    logic [NREQ-1:0]         REQ_READY;
    logic [NREQ*WIDTH-1:0]   REQ_DATA;
    logic [NREQ*CNT_W-1:0]   REQ_AMOUNT;
    logic                    RSP_VALID;
    logic                    RSP_READY;
    logic [WIDTH-1:0]        RSP_DATA;
    logic [ID_W-1:0]         RSP_ID;
    logic [WIDTH-1:0]        SH_DATA;
    logic [WIDTH-1:0]        SH_SHIFTED;
    logic                    BUSY;
    logic [OP_COUNT_W-1:0]   OP_COUNT;

    modport master (
        output REQ_VALID, REQ_DATA, REQ_AMOUNT, RSP_READY, SH_SHIFTED,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ID, SH_DATA, BUSY, OP_COUNT
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_AMOUNT, RSP_READY, SH_SHIFTED,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ID, SH_DATA, BUSY, OP_COUNT
    );
endinterface

// File: rtl/shift_seq_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after i_ptr,
// wrapping. The pointer register is owned by the caller.
module shift_seq_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_grant_idx,
    output logic            o_valid
);
    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        w_idx       = i_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (i_en && !o_valid && i_req[w_idx]) begin
                o_valid        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
            w_idx = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
        end
    end
endmodule

// File: rtl/shift_sequencer.sv
// Shares one single-step shifter among NREQ requesters, one operation at a time.
// Define SHIFT_SEQ_OP_COUNT_EN to build the saturating completed-operation counter.
module shift_sequencer
  import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int CNT_W = $clog2(WIDTH) + 1,
    parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    shift_sequencer_if.slave bus,
    output shift_seq_state_t o_dbg_state
);
    shift_seq_state_t r_state, w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [ID_W-1:0]  r_rsp_id;
    logic [ID_W-1:0]  r_ptr;

    logic [NREQ-1:0]  w_grant;
    logic [ID_W-1:0]  w_grant_idx;
    logic             w_grant_vld;
    logic             w_arb_en;
    logic [WIDTH-1:0] w_req_data;
    logic [CNT_W-1:0] w_req_amount;
    logic [CNT_W-1:0] w_amount_clamped;
    logic [ID_W-1:0]  w_ptr_next;

    // Arbitration is gated while reset is asserted so REQ_READY reads zero then.
    assign w_arb_en = (r_state == IDLE) && RST_N;

    shift_seq_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .i_req       (bus.REQ_VALID),
        .i_ptr       (r_ptr),
        .i_en        (w_arb_en),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_valid     (w_grant_vld)
    );

    assign w_req_data       = bus.REQ_DATA[w_grant_idx*WIDTH +: WIDTH];
    assign w_req_amount     = bus.REQ_AMOUNT[w_grant_idx*CNT_W +: CNT_W];
    assign w_amount_clamped = (w_req_amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : w_req_amount;
    assign w_ptr_next       = (int'(w_grant_idx) == NREQ - 1) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_vld) w_state_next = (w_amount_clamped != '0) ? SHIFT : DONE;
            SHIFT:   if (r_cnt == CNT_W'(1)) w_state_next = DONE;
            DONE:    if (bus.RSP_READY) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.REQ_READY = w_grant;
        bus.RSP_VALID = (r_state == DONE);
        bus.RSP_DATA  = r_acc;
        bus.RSP_ID    = r_rsp_id;
        bus.SH_DATA   = r_acc;
        bus.BUSY      = (r_state != IDLE);
        o_dbg_state   = r_state;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_rsp_id <= '0;
            r_ptr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        r_acc    <= w_req_data;
                        r_cnt    <= w_amount_clamped;
                        r_rsp_id <= w_grant_idx;
                        r_ptr    <= w_ptr_next;
                    end
                end
                SHIFT: begin
                    r_acc <= bus.SH_SHIFTED;
                    r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SHIFT_SEQ_OP_COUNT_EN
    logic [OP_COUNT_W-1:0] r_op_count;

    always_ff @(posedge CLK) begin
        if (!RST_N)
            r_op_count <= '0;
        else if (bus.RSP_VALID && bus.RSP_READY && (r_op_count != '1))
            r_op_count <= r_op_count + 1'b1;
    end

    assign bus.OP_COUNT = r_op_count;
`else
    assign bus.OP_COUNT = '0;
`endif
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed scenarios plus random traffic, checked every
// cycle against a latency-level model of arbitration, shifting and response timing.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int W  = 8;
    localparam int NR = 2;
    localparam int CW = $clog2(W) + 1;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic rst_n;
    shift_seq_state_t dbg_state;

    shift_sequencer_if #(.WIDTH(W), .NREQ(NR), .CNT_W(CW), .ID_W(IW)) bus ();

    shift_sequencer #(.WIDTH(W), .NREQ(NR), .CNT_W(CW), .ID_W(IW)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Shifter stand-in: one left shift per step.
    assign bus.SH_SHIFTED = bus.SH_DATA << 1;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [W-1:0]  exp_q[$];
    int            id_q[$];
    int            rsp_id_log[$];
    bit            m_free = 1'b1;
    bit            m_release = 1'b0;
    int            m_ptr = 0;
    int            m_valid_at = 0;
    logic [15:0]   m_ops = '0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            first_valid_cyc = 0;
    bit            prev_valid = 1'b0;
    int            rsp_count = 0;
    int            acc_count = 0;
    logic [W-1:0]  last_rsp_data;
    int            last_rsp_id;
    logic [NR-1:0] accepted = '0;
    logic [NR-1:0] hold = '0;
    bit            rand_mode = 1'b0;

    int            mg;
    int            mn;
    logic [NR-1:0] m_exp_ready;
    bit            m_exp_valid;
    logic [W-1:0]  m_d;

    function automatic int model_grant(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++)
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_free = 1'b1; m_release = 1'b0; m_ptr = 0; m_ops = '0;
            exp_q.delete(); id_q.delete(); prev_valid = 1'b0; accepted = '0;
        end else begin
            cyc++;
            if (m_release) begin m_free = 1'b1; m_release = 1'b0; end
            mg = model_grant(bus.REQ_VALID, m_ptr);
            m_exp_ready = '0;
            if (m_free && mg >= 0) m_exp_ready[mg] = 1'b1;
            m_exp_valid = !m_free && (cyc >= m_valid_at);
            check("req_ready", 32'(bus.REQ_READY), 32'(m_exp_ready));
            check("ready_onehot", 32'($countones(bus.REQ_READY) <= 1), 32'd1);
            check("busy", 32'(bus.BUSY), 32'(!m_free));
            check("rsp_valid", 32'(bus.RSP_VALID), 32'(m_exp_valid));
            check("op_count", 32'(bus.OP_COUNT), 32'(m_ops));
            if (m_exp_valid && exp_q.size() > 0) begin
                check("rsp_data", 32'(bus.RSP_DATA), 32'(exp_q[0]));
                check("rsp_id", 32'(bus.RSP_ID), 32'(id_q[0]));
            end
            if (bus.RSP_VALID && !prev_valid) first_valid_cyc = cyc;
            prev_valid = bus.RSP_VALID;
            if (m_free && mg >= 0) begin
                mn = int'(bus.REQ_AMOUNT[mg*CW +: CW]);
                if (mn > W) mn = W;
                m_d = bus.REQ_DATA[mg*W +: W];
                m_d = m_d << mn;
                exp_q.push_back(m_d);
                id_q.push_back(mg);
                m_valid_at = cyc + mn + 1;
                m_free = 1'b0;
                m_ptr = (mg + 1) % NR;
                accepted[mg] = 1'b1;
                acc_cyc = cyc;
                acc_count++;
            end else if (m_exp_valid && bus.RSP_VALID && bus.RSP_READY) begin
                last_rsp_data = bus.RSP_DATA;
                last_rsp_id = int'(bus.RSP_ID);
                rsp_id_log.push_back(last_rsp_id);
                if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(id_q.pop_front()); end
                m_release = 1'b1;
                rsp_count++;
`ifdef SHIFT_SEQ_OP_COUNT_EN
                if (m_ops != 16'hFFFF) m_ops++;
`endif
            end
        end
    end

    task automatic drive_req(input int i, input logic [W-1:0] d, input logic [CW-1:0] a);
        bus.REQ_VALID[i] = 1'b1;
        bus.REQ_DATA[i*W +: W] = d;
        bus.REQ_AMOUNT[i*CW +: CW] = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (accepted[i]) begin
                accepted[i] = 1'b0;
                if (!hold[i]) bus.REQ_VALID[i] = 1'b0;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < NR; i++)
                if (!bus.REQ_VALID[i] && $urandom_range(0, 3) == 0)
                    drive_req(i, W'($urandom), CW'($urandom_range(0, 15)));
            bus.RSP_READY = ($urandom_range(0, 9) < 7);
        end
    endtask

    task automatic wait_rsp(input int max_cyc);
        int target;
        int k;
        target = rsp_count + 1;
        k = 0;
        while (rsp_count < target && k < max_cyc) begin step(); k++; end
        check("rsp_wait", 32'(rsp_count), 32'(target));
    endtask

    task automatic wait_accept(input int max_cyc);
        int target;
        int k;
        target = acc_count + 1;
        k = 0;
        while (acc_count < target && k < max_cyc) begin step(); k++; end
        check("accept_wait", 32'(acc_count), 32'(target));
    endtask

    int rr_exp[4] = '{0, 1, 0, 1};
    int saved;
    int k;

    initial begin
        rst_n = 1'b0;
        bus.REQ_VALID = '0;
        bus.REQ_DATA = '0;
        bus.REQ_AMOUNT = '0;
        bus.RSP_READY = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        check("reset_busy", 32'(bus.BUSY), 32'd0);
        check("reset_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        check("reset_rsp_data", 32'(bus.RSP_DATA), 32'd0);
        check("reset_rsp_id", 32'(bus.RSP_ID), 32'd0);
        check("reset_req_ready", 32'(bus.REQ_READY), 32'd0);
        check("reset_op_count", 32'(bus.OP_COUNT), 32'd0);
        step();

        // Single request, amount 3
        drive_req(0, 8'b0000_0001, 4'd3);
        wait_rsp(20);
        check("single_data", 32'(last_rsp_data), 32'h08);
        check("single_id", 32'(last_rsp_id), 32'd0);
        check("single_latency", 32'(first_valid_cyc - acc_cyc), 32'd4);

        // Zero amount passes data through after one cycle
        drive_req(0, 8'hA5, 4'd0);
        wait_rsp(20);
        check("zero_data", 32'(last_rsp_data), 32'hA5);
        check("zero_latency", 32'(first_valid_cyc - acc_cyc), 32'd1);

        // Amount 15 clamps to 8
        drive_req(1, 8'hFF, 4'd15);
        wait_rsp(30);
        check("clamp_data", 32'(last_rsp_data), 32'h00);
        check("clamp_id", 32'(last_rsp_id), 32'd1);
        check("clamp_latency", 32'(first_valid_cyc - acc_cyc), 32'd9);

        // Round-robin with both requesters held valid
        rsp_id_log.delete();
        hold = '1;
        drive_req(0, 8'h11, 4'd1);
        drive_req(1, 8'h22, 4'd1);
        repeat (4) wait_rsp(10);
        bus.REQ_VALID = '0;
        hold = '0;
        for (int i = 0; i < 4; i++)
            check("rr_id", 32'((rsp_id_log.size() > i) ? rsp_id_log[i] : -1), 32'(rr_exp[i]));
        step();

        // Backpressure: response held for 5 cycles
        bus.RSP_READY = 1'b0;
        drive_req(0, 8'h5A, 4'd2);
        wait_accept(10);
        k = 0;
        while (!bus.RSP_VALID && k < 20) begin step(); k++; end
        check("bp_valid", 32'(bus.RSP_VALID), 32'd1);
        drive_req(1, 8'h0F, 4'd1);
        repeat (5) begin
            check("bp_data", 32'(bus.RSP_DATA), 32'h68);
            check("bp_id", 32'(bus.RSP_ID), 32'd0);
            check("bp_req_ready", 32'(bus.REQ_READY), 32'd0);
            step();
        end
        bus.RSP_READY = 1'b1;
        step();
        check("bp_idle", 32'(dbg_state), 32'(IDLE));
        check("bp_busy", 32'(bus.BUSY), 32'd0);
        check("bp_next_grant", 32'(bus.REQ_READY), 32'b10);
        wait_rsp(20);
        check("bp_second_data", 32'(last_rsp_data), 32'h1E);
        check("bp_second_id", 32'(last_rsp_id), 32'd1);

        // Reset during an amount-6 shift
        drive_req(0, 8'h03, 4'd6);
        wait_accept(10);
        step();
        step();
        check("mid_state", 32'(dbg_state), 32'(SHIFT));
        saved = rsp_count;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        check("mid_rst_valid", 32'(bus.RSP_VALID), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        repeat (12) step();
        check("mid_rst_no_rsp", 32'(rsp_count), 32'(saved));

        // Five completed operations
        for (int i = 0; i < 5; i++) begin
            drive_req(i % 2, W'($urandom), CW'($urandom_range(0, 3)));
            wait_rsp(20);
        end
`ifdef SHIFT_SEQ_OP_COUNT_EN
        check("op_count_five", 32'(bus.OP_COUNT), 32'd5);
`else
        check("op_count_off", 32'(bus.OP_COUNT), 32'd0);
`endif

        // Random traffic with random response backpressure
        rand_mode = 1'b1;
        repeat (600) step();
        rand_mode = 1'b0;
        bus.REQ_VALID = '0;
        bus.RSP_READY = 1'b1;
        repeat (30) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(bus.BUSY), 32'd0);
        check("final_op_count", 32'(bus.OP_COUNT), 32'(m_ops));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
